// File: rtl/traffic_phase_ctrl_if.sv
// Control/status bundle for traffic_phase_ctrl: run and emergency requests in,
// lamp aspects and packed-BCD countdowns out.
interface traffic_phase_ctrl_if #(
    parameter int DIGITS = 2
) ();
    logic                en_i;
    logic                emerg_i;
    logic [3:0]          lampa_o;
    logic [3:0]          lampb_o;
    logic [4*DIGITS-1:0] acount_o;
    logic [4*DIGITS-1:0] bcount_o;

    modport master (
        output en_i, emerg_i,
        input  lampa_o, lampb_o, acount_o, bcount_o
    );

    modport slave (
        input  en_i, emerg_i,
        output lampa_o, lampb_o, acount_o, bcount_o
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Two-approach traffic signal controller: one phase FSM drives both lamps, with an
// emergency all-red hold, half-aware resume and per-approach BCD countdown displays.
module traffic_phase_ctrl #(
    parameter int DIGITS    = 2,
    parameter int TICK_DIV  = 1,
    parameter int T_GREEN_A = 40,
    parameter int T_LEFT_A  = 15,
    parameter int T_GREEN_B = 30,
    parameter int T_LEFT_B  = 15,
    parameter int T_YELLOW  = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    traffic_phase_ctrl_if.slave bus
);
    localparam int CW    = 4 * DIGITS;
    localparam int MAXV  = (10 ** DIGITS) - 1;
    localparam int RED_A = T_GREEN_B + T_LEFT_B + 2 * T_YELLOW;
    localparam int RED_B = T_GREEN_A + T_LEFT_A + 2 * T_YELLOW;
    localparam int RW    = $clog2(MAXV + 1);
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [3:0] L_LEFT  = 4'b0001;
    localparam logic [3:0] L_GREEN = 4'b0010;
    localparam logic [3:0] L_YEL   = 4'b0100;
    localparam logic [3:0] L_RED   = 4'b1000;

    if (TICK_DIV < 1 || T_GREEN_A < 2 || T_LEFT_A < 2 || T_GREEN_B < 2 ||
        T_LEFT_B < 2 || T_YELLOW < 2 || T_GREEN_A > MAXV || T_LEFT_A > MAXV ||
        T_GREEN_B > MAXV || T_LEFT_B > MAXV || T_YELLOW > MAXV ||
        RED_A > MAXV || RED_B > MAXV) begin : g_bad_params
        $error("traffic_phase_ctrl: illegal duration/prescale parameters");
    end

    function automatic logic [CW-1:0] to_bcd(input int v);
        logic [CW-1:0] r;
        int            x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x           = x / 10;
        end
        return r;
    endfunction

    // Ripple borrow from the least significant digit; a 0 digit wraps to 9.
    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [CW-1:0] BCD_GA = to_bcd(T_GREEN_A);
    localparam logic [CW-1:0] BCD_LA = to_bcd(T_LEFT_A);
    localparam logic [CW-1:0] BCD_GB = to_bcd(T_GREEN_B);
    localparam logic [CW-1:0] BCD_LB = to_bcd(T_LEFT_B);
    localparam logic [CW-1:0] BCD_Y  = to_bcd(T_YELLOW);
    localparam logic [CW-1:0] BCD_RA = to_bcd(RED_A);
    localparam logic [CW-1:0] BCD_RB = to_bcd(RED_B);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HOLD,
        ST_S0,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_S4,
        ST_S5,
        ST_S6,
        ST_S7
    } state_t;

    function automatic logic [RW-1:0] dur_of(input state_t s);
        case (s)
            ST_S0:                      dur_of = RW'(T_GREEN_A);
            ST_S2:                      dur_of = RW'(T_LEFT_A);
            ST_S4:                      dur_of = RW'(T_GREEN_B);
            ST_S6:                      dur_of = RW'(T_LEFT_B);
            ST_S1, ST_S3, ST_S5, ST_S7: dur_of = RW'(T_YELLOW);
            default:                    dur_of = '0;
        endcase
    endfunction

    function automatic state_t next_of(input state_t s);
        case (s)
            ST_S0:   next_of = ST_S1;
            ST_S1:   next_of = ST_S2;
            ST_S2:   next_of = ST_S3;
            ST_S3:   next_of = ST_S4;
            ST_S4:   next_of = ST_S5;
            ST_S5:   next_of = ST_S6;
            ST_S6:   next_of = ST_S7;
            default: next_of = ST_S0;
        endcase
    endfunction

    function automatic logic [3:0] lamp_a_of(input state_t s);
        case (s)
            ST_S0:        lamp_a_of = L_GREEN;
            ST_S1, ST_S3: lamp_a_of = L_YEL;
            ST_S2:        lamp_a_of = L_LEFT;
            default:      lamp_a_of = L_RED;
        endcase
    endfunction

    function automatic logic [3:0] lamp_b_of(input state_t s);
        case (s)
            ST_S4:        lamp_b_of = L_GREEN;
            ST_S5, ST_S7: lamp_b_of = L_YEL;
            ST_S6:        lamp_b_of = L_LEFT;
            default:      lamp_b_of = L_RED;
        endcase
    endfunction

    // Display value loaded when an approach's lamp changes on entry to s.
    function automatic logic [CW-1:0] aload_of(input state_t s);
        case (s)
            ST_S0:        aload_of = BCD_GA;
            ST_S1, ST_S3: aload_of = BCD_Y;
            ST_S2:        aload_of = BCD_LA;
            default:      aload_of = BCD_RA;
        endcase
    endfunction

    function automatic logic [CW-1:0] bload_of(input state_t s);
        case (s)
            ST_S4:        bload_of = BCD_GB;
            ST_S5, ST_S7: bload_of = BCD_Y;
            ST_S6:        bload_of = BCD_LB;
            default:      bload_of = BCD_RB;
        endcase
    endfunction

    state_t        state_q, state_d, nxt;
    logic          resume_b_q, resume_b_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] acnt_q, acnt_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic [3:0]    lampa_q, lampa_d;
    logic [3:0]    lampb_q, lampb_d;
    logic          tick;
    logic          in_b_half;

    assign in_b_half = (state_q inside {ST_S4, ST_S5, ST_S6, ST_S7});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            resume_b_q <= 1'b0;
            rem_q      <= '0;
            presc_q    <= '0;
            acnt_q     <= '0;
            bcnt_q     <= '0;
            lampa_q    <= L_RED;
            lampb_q    <= L_RED;
        end else begin
            state_q    <= state_d;
            resume_b_q <= resume_b_d;
            rem_q      <= rem_d;
            presc_q    <= presc_d;
            acnt_q     <= acnt_d;
            bcnt_q     <= bcnt_d;
            lampa_q    <= lampa_d;
            lampb_q    <= lampb_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        resume_b_d = resume_b_q;
        rem_d      = rem_q;
        presc_d    = presc_q;
        acnt_d     = acnt_q;
        bcnt_d     = bcnt_q;
        tick       = 1'b0;
        nxt        = next_of(state_q);

        if (!bus.en_i) begin
            state_d = ST_IDLE;
            rem_d   = '0;
            presc_d = '0;
            acnt_d  = '0;
            bcnt_d  = '0;
        end else if (bus.emerg_i) begin
            state_d = ST_HOLD;
            rem_d   = '0;
            presc_d = '0;
            acnt_d  = '0;
            bcnt_d  = '0;
            // Resume in the half that was not interrupted; a cold start resumes at S0.
            if (state_q == ST_IDLE) begin
                resume_b_d = 1'b0;
            end else if (state_q != ST_HOLD) begin
                resume_b_d = !in_b_half;
            end
        end else if (state_q == ST_IDLE || state_q == ST_HOLD) begin
            state_d = (state_q == ST_HOLD && resume_b_q) ? ST_S4 : ST_S0;
            rem_d   = dur_of(state_d);
            presc_d = '0;
            acnt_d  = aload_of(state_d);
            bcnt_d  = bload_of(state_d);
        end else begin
            tick    = (presc_q == PW'(TICK_DIV - 1));
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                if (rem_q > RW'(1)) begin
                    rem_d  = rem_q - RW'(1);
                    acnt_d = bcd_dec(acnt_q);
                    bcnt_d = bcd_dec(bcnt_q);
                end else begin
                    state_d = nxt;
                    rem_d   = dur_of(nxt);
                    acnt_d  = (lamp_a_of(nxt) != lamp_a_of(state_q)) ? aload_of(nxt)
                                                                      : bcd_dec(acnt_q);
                    bcnt_d  = (lamp_b_of(nxt) != lamp_b_of(state_q)) ? bload_of(nxt)
                                                                      : bcd_dec(bcnt_q);
                end
            end
        end

        lampa_d = lamp_a_of(state_d);
        lampb_d = lamp_b_of(state_d);
    end

    assign bus.lampa_o  = lampa_q;
    assign bus.lampb_o  = lampb_q;
    assign bus.acount_o = acnt_q;
    assign bus.bcount_o = bcnt_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: two instances (default timing, and TICK_DIV=4 with
// short yellows) checked each cycle against a time-to-next-lamp-change model.
module tb_traffic_phase_ctrl;
    localparam int IDLE = -2;
    localparam int HOLD = -1;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic em;

    always #5 clk = ~clk;

    traffic_phase_ctrl_if #(.DIGITS(2)) bus0 ();
    traffic_phase_ctrl_if #(.DIGITS(2)) bus1 ();

    assign bus0.en_i    = en;
    assign bus0.emerg_i = em;
    assign bus1.en_i    = en;
    assign bus1.emerg_i = em;

    traffic_phase_ctrl #(.DIGITS(2), .TICK_DIV(1)) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    traffic_phase_ctrl #(.DIGITS(2), .TICK_DIV(4), .T_YELLOW(2)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    int nchecks = 0;
    int nfail   = 0;

    int dur[2][8];
    int td[2];
    int ph[2];
    int rem[2];
    int presc[2];
    int res[2];
    int lamp_a_tab[8] = '{2, 4, 1, 4, 8, 8, 8, 8};
    int lamp_b_tab[8] = '{8, 8, 8, 8, 2, 4, 1, 4};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd8(input int v);
        return 32'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int grp(input int side, input int p);
        if (side == 0) return (p < 4) ? p : 4;
        return (p >= 4) ? p : 0;
    endfunction

    // Seconds until this approach's lamp next changes.
    function automatic int disp(input int i, input int side);
        int s;
        s = rem[i];
        for (int k = ph[i] + 1; k < 8; k++) begin
            if (grp(side, k) != grp(side, ph[i])) break;
            s += dur[i][k];
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ph[i] = IDLE; rem[i] = 0; presc[i] = 0; res[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        if (rst) begin
            ph[i] = IDLE; rem[i] = 0; presc[i] = 0; res[i] = 0;
        end else if (!en) begin
            ph[i] = IDLE; rem[i] = 0; presc[i] = 0;
        end else if (em) begin
            if (ph[i] == IDLE) res[i] = 0;
            else if (ph[i] >= 0) res[i] = (ph[i] < 4) ? 4 : 0;
            ph[i] = HOLD; presc[i] = 0;
        end else if (ph[i] < 0) begin
            ph[i]    = (ph[i] == HOLD) ? res[i] : 0;
            rem[i]   = dur[i][ph[i]];
            presc[i] = 0;
        end else if (presc[i] == td[i] - 1) begin
            presc[i] = 0;
            if (rem[i] > 1) begin
                rem[i]--;
            end else begin
                ph[i]  = (ph[i] + 1) % 8;
                rem[i] = dur[i][ph[i]];
            end
        end else begin
            presc[i]++;
        end
    endtask

    task automatic check_model();
        logic [31:0] la[2], lb[2], ac[2], bc[2];
        logic [31:0] ela, elb, eac, ebc;
        la[0] = 32'(bus0.lampa_o); lb[0] = 32'(bus0.lampb_o);
        ac[0] = 32'(bus0.acount_o); bc[0] = 32'(bus0.bcount_o);
        la[1] = 32'(bus1.lampa_o); lb[1] = 32'(bus1.lampb_o);
        ac[1] = 32'(bus1.acount_o); bc[1] = 32'(bus1.bcount_o);
        for (int i = 0; i < 2; i++) begin
            if (ph[i] < 0) begin
                ela = 8; elb = 8; eac = 0; ebc = 0;
            end else begin
                ela = 32'(lamp_a_tab[ph[i]]);
                elb = 32'(lamp_b_tab[ph[i]]);
                eac = to_bcd8(disp(i, 0));
                ebc = to_bcd8(disp(i, 1));
            end
            chk($sformatf("m%0d_lampa", i), la[i], ela);
            chk($sformatf("m%0d_lampb", i), lb[i], elb);
            chk($sformatf("m%0d_acount", i), ac[i], eac);
            chk($sformatf("m%0d_bcount", i), bc[i], ebc);
            chk($sformatf("m%0d_no_conflict", i), 32'(la[i] == 8 || lb[i] == 8), 1);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
        #1;
        check_model();
    endtask

    initial begin
        dur[0] = '{40, 5, 15, 5, 30, 5, 15, 5};
        dur[1] = '{40, 2, 15, 2, 30, 2, 15, 2};
        td     = '{1, 4};
        rst = 1'b1; en = 1'b0; em = 1'b0;
        model_reset();
        #12;
        chk("rst_lampa", 32'(bus0.lampa_o), 8);
        chk("rst_lampb", 32'(bus0.lampb_o), 8);
        chk("rst_acount", 32'(bus0.acount_o), 0);
        chk("rst_bcount", 32'(bus0.bcount_o), 0);
        check_model();
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 320; r++) begin
            em = (r >= 170 && r <= 172);
            en = !(r == 205 || r == 206);
            cyc();
            if (r == 0) begin
                chk("t1_lampa", 32'(bus0.lampa_o), 2);
                chk("t1_lampb", 32'(bus0.lampb_o), 8);
                chk("t1_acount", 32'(bus0.acount_o), 32'h40);
                chk("t1_bcount", 32'(bus0.bcount_o), 32'h65);
            end
            if (r == 10) begin
                chk("t1_borrow_a", 32'(bus0.acount_o), 32'h30);
                chk("t1_borrow_b", 32'(bus0.bcount_o), 32'h55);
            end
            if (r == 40) begin
                chk("t2_yel_lampa", 32'(bus0.lampa_o), 4);
                chk("t2_yel_acount", 32'(bus0.acount_o), 32'h05);
                chk("t2_yel_bcount", 32'(bus0.bcount_o), 32'h25);
            end
            if (r == 65) begin
                chk("t2_bgreen_lampb", 32'(bus0.lampb_o), 2);
                chk("t2_bgreen_bcount", 32'(bus0.bcount_o), 32'h30);
                chk("t2_bgreen_acount", 32'(bus0.acount_o), 32'h55);
            end
            if (r == 120) begin
                chk("t2_wrap_lampa", 32'(bus0.lampa_o), 2);
                chk("t2_wrap_acount", 32'(bus0.acount_o), 32'h40);
            end
            if (r >= 160 && r <= 163) begin
                chk("t3_y2_lampa", 32'(bus1.lampa_o), 4);
                chk("t3_y2_acount", 32'(bus1.acount_o), 32'h02);
            end
            if (r >= 164 && r <= 167) chk("t3_y1_acount", 32'(bus1.acount_o), 32'h01);
            if (r == 168) chk("t3_s2_lampa", 32'(bus1.lampa_o), 1);
            if (r >= 170 && r <= 172) begin
                chk("t4_hold_lampa", 32'(bus0.lampa_o), 8);
                chk("t4_hold_lampb", 32'(bus0.lampb_o), 8);
                chk("t4_hold_acount", 32'(bus0.acount_o), 0);
                chk("t4_hold_bcount", 32'(bus0.bcount_o), 0);
            end
            if (r == 173) begin
                chk("t4_resume_lampb", 32'(bus0.lampb_o), 2);
                chk("t4_resume_bcount", 32'(bus0.bcount_o), 32'h30);
                chk("t4_resume_acount", 32'(bus0.acount_o), 32'h55);
            end
            if (r == 204) chk("t5_s5_lampb", 32'(bus0.lampb_o), 4);
            if (r == 205) begin
                chk("t5_idle_lampa", 32'(bus0.lampa_o), 8);
                chk("t5_idle_lampb", 32'(bus0.lampb_o), 8);
                chk("t5_idle_acount", 32'(bus0.acount_o), 0);
                chk("t5_idle_bcount", 32'(bus0.bcount_o), 0);
            end
            if (r == 207) begin
                chk("t5_restart_lampa", 32'(bus0.lampa_o), 2);
                chk("t5_restart_acount", 32'(bus0.acount_o), 32'h40);
            end
            if (r == 310) chk("t6_s6_lampb", 32'(bus0.lampb_o), 1);
            if (r == 311) begin
                #2;
                rst = 1'b1;
                #1;
                chk("t6_async_lampa", 32'(bus0.lampa_o), 8);
                chk("t6_async_lampb", 32'(bus0.lampb_o), 8);
                chk("t6_async_bcount", 32'(bus0.bcount_o), 0);
                model_reset();
                check_model();
                @(negedge clk);
                rst = 1'b0;
            end
            if (r == 312) begin
                chk("t6_restart_lampa", 32'(bus0.lampa_o), 2);
                chk("t6_restart_acount", 32'(bus0.acount_o), 32'h40);
                chk("t6_restart_lampa1", 32'(bus1.lampa_o), 2);
            end
        end

        for (int n = 0; n < 3000; n++) begin
            if (en) en = ($urandom_range(0, 499) != 0);
            else    en = ($urandom_range(0, 2) == 0);
            if (em) em = ($urandom_range(0, 3) != 0);
            else    em = ($urandom_range(0, 299) == 0);
            cyc();
            if ($urandom_range(0, 999) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                check_model();
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end
endmodule
